// File: rtl/vh_timing_rx.sv
// Video line/frame timing receiver: registers VSYNC&HSYNC-qualified pixels, tracks x/y position,
// and flags short/long lines and frames over a fixed number of frames.
module vh_timing_rx #(
  parameter int unsigned H_WIDTH = 2448,
  parameter int unsigned V_WIDTH = 2048,
  parameter int unsigned FRM     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        VSYNC,
  input  logic        HSYNC,
  input  logic [31:0] DIN,
  output logic        PIX_VLD,
  output logic [31:0] PIX_DATA,
  output logic [15:0] H_CNT,
  output logic [15:0] V_CNT,
  output logic        SOF,
  output logic        EOL,
  output logic        EOF,
  output logic        LINE_ERR,
  output logic        FRM_ERR,
  output logic [7:0]  FRM_CNT,
  output logic        DONE
);

  typedef enum logic [1:0] {StIdle, StSync, StActive, StFin} state_e;

  state_e      r_state;
  state_e      w_state_nxt;
  logic        r_vs;
  logic        r_pix_vld;
  logic [31:0] r_pix_data;
  logic [15:0] r_h_cnt;
  logic [15:0] r_v_cnt;
  logic [15:0] r_lines;
  logic [7:0]  r_frm_cnt;

  logic        w_vh;
  logic        w_rise;
  logic        w_fall;
  logic        w_active;
  logic        w_cap;
  logic        w_eol;
  logic        w_eof;
  logic        w_last_frm;
  logic [16:0] w_h_len;
  logic [16:0] w_lines;

  assign w_vh     = VSYNC & HSYNC;
  assign w_rise   = VSYNC & ~r_vs;
  assign w_fall   = ~VSYNC & r_vs;
  assign w_active = (r_state == StActive) & enable;
  assign w_cap    = w_active & w_vh;
  // EOL looks one pixel ahead: the registered pixel is last if no pixel follows this cycle.
  assign w_eol    = r_pix_vld & ~w_vh;
  assign w_eof    = w_active & w_fall;
  assign w_h_len  = {1'b0, r_h_cnt} + 17'd1;
  // A line ending together with VSYNC counts toward this frame's total.
  assign w_lines  = {1'b0, r_lines} + {16'd0, w_eol};
  assign w_last_frm = (32'(r_frm_cnt) + 32'd1) >= FRM;

  always_comb begin
    w_state_nxt = r_state;
    if (!enable) begin
      w_state_nxt = StIdle;
    end else begin
      case (r_state)
        StIdle:   if (!VSYNC) w_state_nxt = StSync;
        StSync:   if (w_rise) w_state_nxt = StActive;
        StActive: if (w_fall) w_state_nxt = w_last_frm ? StFin : StSync;
        StFin:    w_state_nxt = StFin;
        default:  w_state_nxt = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_vs       <= 1'b0;
      r_pix_vld  <= 1'b0;
      r_pix_data <= 32'd0;
      r_h_cnt    <= 16'd0;
      r_v_cnt    <= 16'd0;
      r_lines    <= 16'd0;
      r_frm_cnt  <= 8'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_vs      <= VSYNC;
      r_pix_vld <= w_cap;
      if (w_cap) r_pix_data <= DIN;

      if (!enable) begin
        r_h_cnt <= 16'd0;
        r_v_cnt <= 16'd0;
        r_lines <= 16'd0;
      end else if (r_state == StSync) begin
        r_lines <= 16'd0;
      end else if (w_active) begin
        if (w_cap) begin
          if (!r_pix_vld) begin
            r_h_cnt <= 16'd0;
            r_v_cnt <= r_lines;
          end else if (r_h_cnt != 16'hFFFF) begin
            r_h_cnt <= r_h_cnt + 16'd1;
          end
        end
        if (w_eol && (r_lines != 16'hFFFF)) r_lines <= r_lines + 16'd1;
      end

      if (w_eof && (r_frm_cnt != 8'hFF)) r_frm_cnt <= r_frm_cnt + 8'd1;
    end
  end

  assign PIX_VLD  = r_pix_vld;
  assign PIX_DATA = r_pix_data;
  assign H_CNT    = r_h_cnt;
  assign V_CNT    = r_v_cnt;
  assign SOF      = r_pix_vld & (r_h_cnt == 16'd0) & (r_v_cnt == 16'd0);
  assign EOL      = w_eol;
  assign EOF      = w_eof;
  assign LINE_ERR = w_eol & (w_h_len != 17'(H_WIDTH));
  assign FRM_ERR  = w_eof & (w_lines != 17'(V_WIDTH));
  assign FRM_CNT  = r_frm_cnt;
  assign DONE     = (r_state == StFin);

endmodule

// File: tb/tb_vh_timing_rx.sv
// Directed bench for vh_timing_rx with a 4x3 frame and two frames to DONE.
module tb_vh_timing_rx;
  localparam int unsigned HW = 4;
  localparam int unsigned VW = 3;
  localparam int unsigned NF = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        VSYNC;
  logic        HSYNC;
  logic [31:0] DIN;
  logic        PIX_VLD;
  logic [31:0] PIX_DATA;
  logic [15:0] H_CNT;
  logic [15:0] V_CNT;
  logic        SOF;
  logic        EOL;
  logic        EOF;
  logic        LINE_ERR;
  logic        FRM_ERR;
  logic [7:0]  FRM_CNT;
  logic        DONE;

  int total = 0;
  int bad = 0;
  int n_pix = 0, n_sof = 0, n_eol = 0, n_eof = 0, n_lerr = 0, n_ferr = 0;
  logic [31:0] seq = 32'hA000_0000;
  logic [31:0] prev_din;

  always #5 clk = ~clk;

  vh_timing_rx #(.H_WIDTH(HW), .V_WIDTH(VW), .FRM(NF)) dut (
    .clk(clk), .rst(rst), .enable(enable), .VSYNC(VSYNC), .HSYNC(HSYNC), .DIN(DIN),
    .PIX_VLD(PIX_VLD), .PIX_DATA(PIX_DATA), .H_CNT(H_CNT), .V_CNT(V_CNT), .SOF(SOF),
    .EOL(EOL), .EOF(EOF), .LINE_ERR(LINE_ERR), .FRM_ERR(FRM_ERR), .FRM_CNT(FRM_CNT),
    .DONE(DONE)
  );

  // Event tallies, sampled mid-cycle after the inputs for that cycle have settled.
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      if (PIX_VLD)  n_pix++;
      if (SOF)      n_sof++;
      if (EOL)      n_eol++;
      if (EOF)      n_eof++;
      if (LINE_ERR) n_lerr++;
      if (FRM_ERR)  n_ferr++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    chk(tag, 32'(obs), 32'(exp));
  endtask

  task automatic tick(input logic e, input logic v, input logic h);
    @(negedge clk);
    prev_din = DIN;
    enable = e;
    VSYNC = v;
    HSYNC = h;
    DIN = seq;
    seq = seq + 32'd1;
    #3;
  endtask

  // n pixels on line v, then one terminating cycle with VSYNC=vt, HSYNC=0.
  task automatic send_line(input int n, input int v, input logic vt);
    for (int i = 0; i < n; i++) begin
      tick(1'b1, 1'b1, 1'b1);
      if (i == 0) begin
        chk1("line_start_vld", PIX_VLD, 1'b0);
      end else begin
        chk1("pix_vld", PIX_VLD, 1'b1);
        chk("h_cnt", H_CNT, 32'(i - 1));
        chk("pix_data", PIX_DATA, prev_din);
        chk1("eol_early", EOL, 1'b0);
        if (i == 1) chk1("sof", SOF, v == 0);
      end
    end
    tick(1'b1, vt, 1'b0);
    chk1("eol_vld", PIX_VLD, 1'b1);
    chk1("eol", EOL, 1'b1);
    chk("eol_h", H_CNT, 32'(n - 1));
    chk("eol_v", V_CNT, 32'(v));
    chk1("line_err", LINE_ERR, n != int'(HW));
  endtask

  task automatic chk_counts(input string tag, input int p, input int s, input int l,
                            input int f, input int le, input int fe);
    chk({tag, "_pix"}, 32'(n_pix), 32'(p));
    chk({tag, "_sof"}, 32'(n_sof), 32'(s));
    chk({tag, "_eol"}, 32'(n_eol), 32'(l));
    chk({tag, "_eof"}, 32'(n_eof), 32'(f));
    chk({tag, "_lerr"}, 32'(n_lerr), 32'(le));
    chk({tag, "_ferr"}, 32'(n_ferr), 32'(fe));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; enable = 1'b0; VSYNC = 1'b0; HSYNC = 1'b0; DIN = 32'd0; prev_din = 32'd0;
    repeat (2) @(negedge clk);
    #3;
    chk1("rst_vld", PIX_VLD, 1'b0);
    chk("rst_data", PIX_DATA, 32'd0);
    chk("rst_frm_cnt", 32'(FRM_CNT), 32'd0);
    chk1("rst_done", DONE, 1'b0);

    // Release reset in the middle of a frame: must not lock until VSYNC goes low.
    enable = 1'b1; VSYNC = 1'b1; HSYNC = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b0);
    chk("midframe_pix", 32'(n_pix), 32'd0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);

    // Frame 1: gap after the last line, then VSYNC falls.
    tick(1'b1, 1'b1, 1'b0);
    send_line(4, 0, 1'b1);
    send_line(4, 1, 1'b1);
    send_line(4, 2, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk1("f1_eof", EOF, 1'b1);
    chk1("f1_frm_err", FRM_ERR, 1'b0);
    chk1("f1_eof_eol", EOL, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("f1_frm_cnt", 32'(FRM_CNT), 32'd1);
    chk1("f1_done", DONE, 1'b0);
    chk_counts("f1", 12, 1, 3, 1, 0, 0);

    // Frame 2: last line ends with HSYNC and VSYNC falling together.
    tick(1'b1, 1'b1, 1'b0);
    send_line(4, 0, 1'b1);
    send_line(4, 1, 1'b1);
    send_line(4, 2, 1'b0);
    chk1("f2_eof", EOF, 1'b1);
    chk1("f2_frm_err", FRM_ERR, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    chk("f2_frm_cnt", 32'(FRM_CNT), 32'd2);
    chk1("f2_done", DONE, 1'b1);
    chk_counts("f2", 24, 2, 6, 2, 0, 0);

    // Finished: further frames are ignored.
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    chk("fin_pix", 32'(n_pix), 32'd24);
    chk1("fin_done", DONE, 1'b1);

    // Drop enable, re-enable inside a frame: waits for VSYNC low.
    tick(1'b0, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk1("en_done_clr", DONE, 1'b0);
    chk("en_frm_cnt", 32'(FRM_CNT), 32'd2);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    chk("en_relock_pix", 32'(n_pix), 32'd24);
    tick(1'b1, 1'b0, 1'b0);

    // Frame 3: short first line, then VSYNC drops after only two lines.
    tick(1'b1, 1'b1, 1'b0);
    send_line(3, 0, 1'b1);
    send_line(4, 1, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk1("f3_eof", EOF, 1'b1);
    chk1("f3_frm_err", FRM_ERR, 1'b1);
    tick(1'b1, 1'b0, 1'b0);
    chk("f3_frm_cnt", 32'(FRM_CNT), 32'd3);
    chk_counts("f3", 31, 3, 8, 3, 1, 1);

    // Enable drop in the middle of a line.
    tick(1'b0, 1'b0, 1'b0);
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk("drop_h0", H_CNT, 32'd0);
    tick(1'b0, 1'b1, 1'b1);
    chk1("drop_vld_before", PIX_VLD, 1'b1);
    tick(1'b0, 1'b1, 1'b1);
    chk1("drop_vld_after", PIX_VLD, 1'b0);
    chk("drop_frm_cnt", 32'(FRM_CNT), 32'd3);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk("drop_relock_pix", 32'(n_pix), 32'd33);

    // Relock, then assert reset between clock edges.
    tick(1'b1, 1'b0, 1'b0);
    tick(1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    tick(1'b1, 1'b1, 1'b1);
    chk1("pre_rst_vld", PIX_VLD, 1'b1);
    chk("pre_rst_h", H_CNT, 32'd1);
    rst = 1'b1;
    #1;
    chk1("arst_vld", PIX_VLD, 1'b0);
    chk("arst_data", PIX_DATA, 32'd0);
    chk("arst_h", H_CNT, 32'd0);
    chk("arst_v", V_CNT, 32'd0);
    chk1("arst_sof", SOF, 1'b0);
    chk1("arst_eol", EOL, 1'b0);
    chk1("arst_eof", EOF, 1'b0);
    chk1("arst_lerr", LINE_ERR, 1'b0);
    chk1("arst_ferr", FRM_ERR, 1'b0);
    chk("arst_frm_cnt", 32'(FRM_CNT), 32'd0);
    chk1("arst_done", DONE, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vh_timing_rx.md
VH_TIMING_RX -- requirements
Module: vh_timing_rx

Interface
REQ-001 SHALL have parameter H_WIDTH, default 2448: expected active pixels per line.
REQ-002 SHALL have parameter V_WIDTH, default 2048: expected active lines per frame.
REQ-003 SHALL have parameter FRM, default 3: number of frames to receive before DONE.
REQ-004 SHALL have port clk  in  1  sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst  in  1  reset; asynchronous, active-high.
REQ-006 SHALL have port enable  in  1  receive enable; low forces IDLE.
REQ-007 SHALL have port VSYNC  in  1  frame-active strobe.
REQ-008 SHALL have port HSYNC  in  1  line-active strobe; a pixel is valid when VSYNC&HSYNC.
REQ-009 SHALL have port DIN  in  32  pixel data, sampled with VSYNC&HSYNC.
REQ-010 SHALL have port PIX_VLD  out  1  registered pixel valid.
REQ-011 SHALL have port PIX_DATA  out  32  registered pixel data.
REQ-012 SHALL have port H_CNT  out  16  x coordinate of the current PIX_VLD pixel.
REQ-013 SHALL have port V_CNT  out  16  y coordinate of the current PIX_VLD pixel.
REQ-014 SHALL have port SOF  out  1  pulse on the first pixel of a frame.
REQ-015 SHALL have port EOL  out  1  pulse on the last pixel of a line.
REQ-016 SHALL have port EOF  out  1  one-cycle pulse on VSYNC falling edge within a frame.
REQ-017 SHALL have port LINE_ERR  out  1  one-cycle pulse: completed line length != H_WIDTH.
REQ-018 SHALL have port FRM_ERR  out  1  one-cycle pulse, coincident with EOF: line count != V_WIDTH.
REQ-019 SHALL have port FRM_CNT  out  8  completed frames.
REQ-020 SHALL have port DONE  out  1  level, high once FRM_CNT == FRM.

Function
REQ-021 SHALL implement states IDLE, SYNC, ACTIVE, FIN.
REQ-022 SHALL transition IDLE->SYNC when enable=1 and VSYNC=0; this prevents locking mid-frame.
REQ-023 SHALL transition SYNC->ACTIVE on the VSYNC rising edge.
REQ-024 SHALL transition ACTIVE->SYNC on the VSYNC falling edge if FRM_CNT+1 < FRM, else ACTIVE->FIN.
REQ-025 SHALL remain in FIN, DONE=1, until reset or enable=0.
REQ-026 SHALL force state to IDLE within one cycle of enable=0 from any state, clearing line/pixel counters but not FRM_CNT.
REQ-027 SHALL register pixels only in ACTIVE: PIX_VLD(t+1)=VSYNC&HSYNC(t) and PIX_DATA(t+1)=DIN(t); latency is exactly 1 cycle.
REQ-028 SHALL ignore HSYNC pulses while VSYNC=0 and in IDLE/SYNC/FIN: no PIX_VLD and no counting.
REQ-029 SHALL set H_CNT to 0 on the first pixel of each line and increment it by 1 per subsequent pixel, saturating at 16'hFFFF.
REQ-030 SHALL set V_CNT to 0 for the first line of a frame and increment it by 1 per completed line, saturating at 16'hFFFF.
REQ-031 SHALL assert SOF with PIX_VLD when H_CNT=0 and V_CNT=0.
REQ-032 SHALL assert EOL with PIX_VLD when the current-cycle input VSYNC&HSYNC=0; this is one-pixel lookahead.
REQ-033 SHALL pulse LINE_ERR in the cycle EOL is high if H_CNT+1 != H_WIDTH.
REQ-034 SHALL treat a line terminated by VSYNC falling as a complete line, with EOL and a LINE_ERR check as normal.
REQ-035 SHALL pulse EOF and FRM_ERR one cycle after VSYNC falls in ACTIVE, FRM_ERR if completed lines != V_WIDTH; FRM_CNT SHALL increment in the same cycle, saturating at 255.
REQ-036 SHALL accept a 1-pixel line (HSYNC high for one cycle): SOF/EOL may coincide, H_CNT=0.
REQ-037 SHALL accept HSYNC and VSYNC falling in the same cycle: EOL in cycle t+1, EOF in cycle t+1, V_CNT count includes that line.

Reset
REQ-038 SHALL, on rst=1 and asynchronously, set state=IDLE and clear all outputs and counters to 0 (PIX_DATA=0, DONE=0, FRM_CNT=0).
REQ-039 SHALL, on reset released mid-frame, not lock until VSYNC is next low, per REQ-022.

Verification
REQ-040 SHALL verify a nominal frame: H_WIDTH=4, V_WIDTH=3, FRM=2, with 2 clean frames. Required response: 12 PIX_VLD per frame, H_CNT 0..3, V_CNT 0..2, SOF x2, EOL x6, EOF x2, no errors, FRM_CNT=2, DONE=1.
REQ-041 SHALL verify short-line detection: 3-pixel line in a 4-wide frame. Required response: LINE_ERR pulse with that EOL; next line H_CNT restarts at 0.
REQ-042 SHALL verify frame-count error: VSYNC drops after 2 lines with V_WIDTH=3. Required response: EOF and FRM_ERR in the same cycle; FRM_CNT increments.
REQ-043 SHALL verify mid-frame start: rst released while VSYNC=1 and HSYNC toggling. Required response: no PIX_VLD until VSYNC falls then rises; first pixel carries SOF.
REQ-044 SHALL verify enable drop: enable=0 mid-line. Required response: PIX_VLD=0 next cycle; FRM_CNT unchanged; relock only after VSYNC low.
REQ-045 SHALL verify the async reset: rst asserted mid-pixel off a clock edge. Required response: all outputs 0 immediately, before the next clk edge.
